// File: rtl/nx_event_interrupt_coalesce.sv
// Event-interrupt register block with software set and count/timeout interrupt coalescing.
// Optional OVF register at address 7 is built only when NX_EVENT_INT_OVERFLOW_EN is defined.

module nx_event_interrupt_coalesce #(
  parameter int N_ADDR_BITS = 16,
  parameter int N_INT_BITS  = 16,
  parameter int N_CNT_BITS  = 8,
  parameter int N_TMR_BITS  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_ADDR_BITS-1:0] reg_addr,
  input  logic                   rd_stb,
  input  logic                   wr_stb,
  input  logic [N_INT_BITS-1:0]  int_stb,
  input  logic [N_INT_BITS-1:0]  int_data_in,
  output logic [N_INT_BITS-1:0]  int_data_out,
  output logic                   int_ack,
  output logic                   int_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  localparam logic [N_CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [N_TMR_BITS-1:0] TMR_MAX = '1;

`ifndef SYNTHESIS
  if (N_INT_BITS < 1 || N_CNT_BITS > N_INT_BITS || N_TMR_BITS > N_INT_BITS) begin : g_param_check
    $error("nx_event_interrupt_coalesce: illegal parameter combination");
  end
`endif

  logic [7:0]            w_sel;
  logic                  w_wr_raw;
  logic                  w_wr_mask;
  logic                  w_wr_set;
  logic                  w_wr_thr;
  logic                  w_wr_tmo;
  logic [N_INT_BITS-1:0] w_raw_clr;
  logic [N_INT_BITS-1:0] w_raw_set;
  logic [N_INT_BITS-1:0] w_raw_next;
  logic [N_INT_BITS-1:0] w_ovf_rd;

  logic [N_INT_BITS-1:0] r_raw;
  logic [N_INT_BITS-1:0] r_mask;
  logic [N_CNT_BITS-1:0] r_thr;
  logic [N_TMR_BITS-1:0] r_tmo;

  state_t                r_state;
  state_t                w_state_next;
  logic [N_CNT_BITS-1:0] r_cnt;
  logic [N_CNT_BITS-1:0] w_cnt_next;
  logic [N_TMR_BITS-1:0] r_tmr;
  logic [N_TMR_BITS-1:0] w_tmr_next;
  logic                  r_int_out;
  logic                  w_int_out_next;

  logic                  w_ev;
  logic                  w_any;
  logic                  w_legacy;
  logic [N_CNT_BITS:0]   w_cnt_sum;
  logic [N_TMR_BITS:0]   w_tmr_sum;
  logic                  w_cnt_hit;
  logic                  w_tmo_hit;
  logic [N_CNT_BITS-1:0] w_cnt_inc;
  logic [N_TMR_BITS-1:0] w_tmr_inc;

  genvar gi;

  // Full-width address compare so that aliases above address 7 decode to nothing.
  generate
    for (gi = 0; gi < 8; gi++) begin : g_sel
      assign w_sel[gi] = (reg_addr == N_ADDR_BITS'(gi));
    end
  endgenerate

  assign w_wr_raw  = wr_stb & w_sel[0];
  assign w_wr_mask = wr_stb & w_sel[2];
  assign w_wr_set  = wr_stb & w_sel[3];
  assign w_wr_thr  = wr_stb & w_sel[4];
  assign w_wr_tmo  = wr_stb & w_sel[5];

  assign w_raw_clr = w_wr_raw ? int_data_in : '0;
  assign w_raw_set = w_wr_set ? int_data_in : '0;

  // Both set sources override a same-cycle write-1-to-clear.
  generate
    for (gi = 0; gi < N_INT_BITS; gi++) begin : g_raw
      assign w_raw_next[gi] = int_stb[gi] | w_raw_set[gi] | (r_raw[gi] & ~w_raw_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw  <= '0;
      r_mask <= '0;
      r_thr  <= '0;
      r_tmo  <= '0;
    end else begin
      r_raw <= w_raw_next;
      if (w_wr_mask) r_mask <= int_data_in;
      if (w_wr_thr)  r_thr  <= int_data_in[N_CNT_BITS-1:0];
      if (w_wr_tmo)  r_tmo  <= int_data_in[N_TMR_BITS-1:0];
    end
  end

`ifdef NX_EVENT_INT_OVERFLOW_EN
  logic                  w_wr_ovf;
  logic [N_INT_BITS-1:0] w_ovf_clr;
  logic [N_INT_BITS-1:0] w_ovf_next;
  logic [N_INT_BITS-1:0] r_ovf;

  assign w_wr_ovf  = wr_stb & w_sel[7];
  assign w_ovf_clr = w_wr_ovf ? int_data_in : '0;

  // A repeat strobe only counts as overflow if RAW is not being cleared underneath it.
  generate
    for (gi = 0; gi < N_INT_BITS; gi++) begin : g_ovf
      assign w_ovf_next[gi] = (int_stb[gi] & r_raw[gi] & ~w_raw_clr[gi])
                            | (r_ovf[gi] & ~w_ovf_clr[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
    end else begin
      r_ovf <= w_ovf_next;
    end
  end

  assign w_ovf_rd = r_ovf;
`else
  assign w_ovf_rd = '0;
`endif

  assign w_ev      = |(int_stb & r_mask);
  assign w_any     = |(r_raw & r_mask);
  assign w_legacy  = (r_thr == '0);

  // One extra bit keeps the threshold/timeout compares free of wrap-around.
  assign w_cnt_sum = {1'b0, r_cnt} + (N_CNT_BITS+1)'(w_ev);
  assign w_tmr_sum = {1'b0, r_tmr} + (N_TMR_BITS+1)'(1);
  assign w_cnt_hit = (w_cnt_sum >= {1'b0, r_thr});
  assign w_tmo_hit = (r_tmo != '0) && (w_tmr_sum >= {1'b0, r_tmo});
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_tmr_inc = (r_tmr == TMR_MAX) ? r_tmr : r_tmr + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_tmr     <= '0;
      r_int_out <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_tmr     <= w_tmr_next;
      r_int_out <= w_int_out_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_tmr_next     = r_tmr;
    w_int_out_next = 1'b0;
    if (w_legacy) begin
      w_state_next   = S_IDLE;
      w_cnt_next     = '0;
      w_tmr_next     = '0;
      w_int_out_next = w_any;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_next = '0;
          w_tmr_next = '0;
          if (w_ev) begin
            w_cnt_next   = N_CNT_BITS'(1);
            w_state_next = (r_thr == N_CNT_BITS'(1)) ? S_FIRE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          w_tmr_next = w_tmr_inc;
          if (w_ev) w_cnt_next = w_cnt_inc;
          if (w_cnt_hit || w_tmo_hit) begin
            w_state_next = S_FIRE;
          end else if (!w_any && !w_ev) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_tmr_next   = '0;
          end
        end
        S_FIRE: begin
          w_int_out_next = w_any;
          if (!w_any) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_tmr_next   = '0;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
          w_tmr_next   = '0;
        end
      endcase
    end
  end

  always_comb begin
    int_data_out = '0;
    if (w_sel[0])      int_data_out = r_raw;
    else if (w_sel[1]) int_data_out = r_raw & r_mask;
    else if (w_sel[2]) int_data_out = r_mask;
    else if (w_sel[4]) int_data_out = N_INT_BITS'(r_thr);
    else if (w_sel[5]) int_data_out = N_INT_BITS'(r_tmo);
    else if (w_sel[6]) int_data_out = N_INT_BITS'(r_cnt);
    else if (w_sel[7]) int_data_out = w_ovf_rd;
  end

  assign int_ack = rd_stb | wr_stb;
  assign int_out = r_int_out;

endmodule
